tone_detect: RTL and testbench
==============================

TONE_DETECT -- requirements
Module: tone_detect

Interface
REQ-001 Parameter CLK_HZ, default 100000000: clock frequency in Hz.
REQ-002 Parameter TONE_LO_HZ, default 440: low siren tone; PERIOD_LO = CLK_HZ/TONE_LO_HZ (integer division).
REQ-003 Parameter TONE_HI_HZ, default 880: high siren tone; PERIOD_HI = CLK_HZ/TONE_HI_HZ.
REQ-004 Parameter TOL_CYC, default 2000: classification tolerance in clock cycles.
REQ-005 Parameter CNT_W, default 20: width of the period counter and output; TIMEOUT = 2*PERIOD_LO SHALL be less than 2^CNT_W.
REQ-006 CLK100MHZ  input  1  sole clock; all state updates on its rising edge.
REQ-007 ck_rst  input  1  asynchronous, active-low reset.
REQ-008 audio_in  input  1  asynchronous square-wave tone input, e.g. from a PMOD pin.
REQ-009 period  output  CNT_W  last measured rising-edge-to-rising-edge period, in cycles.
REQ-010 period_valid  output  1  one-cycle strobe; period updated this cycle.
REQ-011 tone  output  2  confirmed tone: 00 none, 01 low, 10 high, 11 unknown.
REQ-012 siren_count  output  8  number of confirmed low<->high tone changes.

Function
REQ-013 audio_in SHALL pass through a two-flop synchronizer; a third flop holds the previous level; an edge is synchronized level high and previous level low.
REQ-014 States: IDLE (no edge since reset or timeout), ARMED (one edge seen), TRACK (at least one period measured).
REQ-015 IDLE: cycle counter held at 0; an edge moves to ARMED, counter loaded with 1, no period_valid.
REQ-016 ARMED/TRACK: counter increments each cycle without an edge, saturating at TIMEOUT; an edge loads period with the counter value, loads the counter with 1, pulses period_valid, and moves to TRACK.
REQ-017 Counter reaching TIMEOUT in ARMED/TRACK: move to IDLE, tone <= 00, confirmation cleared, period unchanged, no period_valid.
REQ-018 Edge in the same cycle the counter equals TIMEOUT: timeout applies, then the edge re-arms (state ARMED, counter 1); no period_valid.
REQ-019 Latency: period_valid SHALL assert exactly 3 cycles after the first clock edge that samples audio_in high.
REQ-020 Classification per measured period P: |P-PERIOD_HI| <= TOL_CYC -> high; else |P-PERIOD_LO| <= TOL_CYC -> low; else unknown. Comparison uses unsigned CNT_W+1-bit difference, no wrap.
REQ-021 tone SHALL change to a class only after two consecutive measured periods of that class; updated in the same cycle as the second period_valid.
REQ-022 siren_count increments by 1 when tone changes 01->10 or 10->01; saturates at 255; changes through 00 or 11 do not count.
REQ-023 All outputs registered; no combinational path from audio_in to any output.

Reset
REQ-024 ck_rst low asynchronously clears: synchronizer flops, counter, period = 0, period_valid = 0, tone = 00, siren_count = 0, state IDLE, confirmation cleared.
REQ-025 Reset release is synchronous to CLK100MHZ.
REQ-026 Reset mid-measurement discards the partial period; the first post-reset edge only arms.

Configuration
REQ-027 Macro TONE_DETECT_GLITCH_FILTER_EN defined: synchronized level SHALL be accepted as changed only after 3 consecutive equal samples; edge latency becomes 5 cycles (REQ-019); pulses shorter than 3 cycles are ignored.
REQ-028 Macro undefined: no filter; behaviour exactly as REQ-013 and REQ-019.

Verification (CLK_HZ=1000, TONE_LO_HZ=10, TONE_HI_HZ=20, TOL_CYC=5, CNT_W=20: PERIOD_LO=100, PERIOD_HI=50, TIMEOUT=200)
REQ-029 Square wave, period 100 cycles, 5 periods -> first period_valid on 2nd edge with period=100; tone=01 after 2nd valid; siren_count=0.
REQ-030 4 periods of 50, then 4 of 100, then 4 of 50 -> tone 10, 01, 10; siren_count=2; single 103-cycle period inside the 50s leaves tone=10.
REQ-031 Periods of 75 -> period=75 strobes, tone=11 after 2nd; siren_count unchanged.
REQ-032 Input held low 200 cycles after an edge -> tone=00, state IDLE, no strobe; next edge gives no period_valid.
REQ-033 Assert ck_rst mid-period while tone=10 -> all outputs 0 immediately, before next clock edge.
REQ-034 With TONE_DETECT_GLITCH_FILTER_EN: 2-cycle high glitches mid-period 100 -> no extra strobes, period=100; latency 5 cycles.

Source files
------------

// File: rtl/tone_detect.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tone_detect
//  Purpose  : Measures the rising-edge-to-rising-edge period of an
//             asynchronous square-wave input, classifies each period as the
//             low or high siren tone (or unknown), confirms a tone after two
//             consecutive periods of the same class, and counts confirmed
//             low<->high alternations.
//  Ports    : CLK100MHZ    - sole clock, rising edge
//             ck_rst       - asynchronous active-low reset
//             audio_in     - asynchronous square-wave input
//             period       - last measured period in clock cycles
//             period_valid - one-cycle strobe, period updated this cycle
//             tone         - 00 none, 01 low, 10 high, 11 unknown
//             siren_count  - confirmed low<->high changes, saturating
//  Options  : TONE_DETECT_GLITCH_FILTER_EN - when defined, the synchronized
//             level only changes after 3 consecutive equal samples
//             (edge latency 5 cycles instead of 3).
//  Revision : 1.0 - initial release
// ============================================================================
module tone_detect #(
  parameter int CLK_HZ     = 100000000,
  parameter int TONE_LO_HZ = 440,
  parameter int TONE_HI_HZ = 880,
  parameter int TOL_CYC    = 2000,
  parameter int CNT_W      = 20
) (
  input  logic             CLK100MHZ,
  input  logic             ck_rst,
  input  logic             audio_in,
  output logic [CNT_W-1:0] period,
  output logic             period_valid,
  output logic [1:0]       tone,
  output logic [7:0]       siren_count
);

  localparam int PERIOD_LO = CLK_HZ / TONE_LO_HZ;
  localparam int PERIOD_HI = CLK_HZ / TONE_HI_HZ;

  localparam logic [CNT_W-1:0] TIMEOUT  = CNT_W'(2 * PERIOD_LO);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W:0]   PER_LO_X = (CNT_W+1)'(PERIOD_LO);
  localparam logic [CNT_W:0]   PER_HI_X = (CNT_W+1)'(PERIOD_HI);
  localparam logic [CNT_W:0]   TOL_X    = (CNT_W+1)'(TOL_CYC);

  localparam logic [1:0] TONE_NONE = 2'b00;
  localparam logic [1:0] TONE_LOW  = 2'b01;
  localparam logic [1:0] TONE_HIGH = 2'b10;
  localparam logic [1:0] TONE_UNK  = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    TRACK = 2'd2
  } state_t;

  // --------------------------------------------------------------------------
  // Input conditioning: two-flop synchronizer, one conditioning stage
  // (plain delay, or the 3-sample glitch filter), then the previous-level flop.
  // The conditioning stage sets the edge-to-strobe latency.
  // --------------------------------------------------------------------------
  logic sync1;
  logic sync2;
  logic level;
  logic level_prev;
  logic edge_det;

`ifdef TONE_DETECT_GLITCH_FILTER_EN
  logic hist1;
  logic hist2;

  always_ff @(posedge CLK100MHZ or negedge ck_rst) begin
    if (!ck_rst) begin
      sync1      <= 1'b0;
      sync2      <= 1'b0;
      hist1      <= 1'b0;
      hist2      <= 1'b0;
      level      <= 1'b0;
      level_prev <= 1'b0;
    end else begin
      sync1      <= audio_in;
      sync2      <= sync1;
      hist1      <= sync2;
      hist2      <= hist1;
      // Accept a new level only once three successive samples agree.
      if ((sync2 == hist1) && (hist1 == hist2)) begin
        level <= sync2;
      end
      level_prev <= level;
    end
  end
`else
  always_ff @(posedge CLK100MHZ or negedge ck_rst) begin
    if (!ck_rst) begin
      sync1      <= 1'b0;
      sync2      <= 1'b0;
      level      <= 1'b0;
      level_prev <= 1'b0;
    end else begin
      sync1      <= audio_in;
      sync2      <= sync1;
      level      <= sync2;
      level_prev <= level;
    end
  end
`endif

  assign edge_det = level & ~level_prev;

  // --------------------------------------------------------------------------
  // Period classification on the running count (used when an edge closes it).
  // Differences are taken one bit wider than the counter so they never wrap.
  // --------------------------------------------------------------------------
  logic [CNT_W-1:0] cnt;
  logic [CNT_W:0]   cnt_x;
  logic [CNT_W:0]   diff_hi;
  logic [CNT_W:0]   diff_lo;
  logic [1:0]       cls;

  always_comb begin
    cnt_x   = {1'b0, cnt};
    diff_hi = (cnt_x >= PER_HI_X) ? (cnt_x - PER_HI_X) : (PER_HI_X - cnt_x);
    diff_lo = (cnt_x >= PER_LO_X) ? (cnt_x - PER_LO_X) : (PER_LO_X - cnt_x);
    if (diff_hi <= TOL_X) begin
      cls = TONE_HIGH;
    end else if (diff_lo <= TOL_X) begin
      cls = TONE_LOW;
    end else begin
      cls = TONE_UNK;
    end
  end

  // A confirmed change counts only when it swaps directly between low and high.
  logic siren_flip;
  assign siren_flip = ((tone == TONE_LOW)  && (cls == TONE_HIGH)) ||
                      ((tone == TONE_HIGH) && (cls == TONE_LOW));

  // --------------------------------------------------------------------------
  // Measurement / confirmation state machine
  // --------------------------------------------------------------------------
  state_t     state;
  logic [1:0] cand;        // class of the previous measured period
  logic       cand_valid;  // cand holds a period from the current run

  always_ff @(posedge CLK100MHZ or negedge ck_rst) begin
    if (!ck_rst) begin
      state        <= IDLE;
      cnt          <= '0;
      period       <= '0;
      period_valid <= 1'b0;
      tone         <= TONE_NONE;
      siren_count  <= 8'd0;
      cand         <= TONE_NONE;
      cand_valid   <= 1'b0;
    end else begin
      period_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (edge_det) begin
            state <= ARMED;
            cnt   <= CNT_ONE;
          end else begin
            cnt   <= '0;
          end
        end

        ARMED, TRACK: begin
          if (cnt == TIMEOUT) begin
            // Timeout wins over a coincident edge; that edge only re-arms.
            tone       <= TONE_NONE;
            cand_valid <= 1'b0;
            if (edge_det) begin
              state <= ARMED;
              cnt   <= CNT_ONE;
            end else begin
              state <= IDLE;
              cnt   <= '0;
            end
          end else if (edge_det) begin
            period       <= cnt;
            period_valid <= 1'b1;
            cnt          <= CNT_ONE;
            state        <= TRACK;
            cand         <= cls;
            cand_valid   <= 1'b1;
            if (cand_valid && (cand == cls) && (tone != cls)) begin
              tone <= cls;
              if (siren_flip && (siren_count != 8'hFF)) begin
                siren_count <= siren_count + 8'd1;
              end
            end
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end

        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_tone_detect.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_tone_detect
//  Purpose  : Self-checking bench for tone_detect with small parameters
//             (PERIOD_LO=100, PERIOD_HI=50, TIMEOUT=200). Table rows give a
//             period length and the tone/siren_count expected once that
//             period is measured; expectations are queued when the closing
//             rising edge is driven and compared when period_valid fires.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_tone_detect;

  localparam int CNT_W   = 20;
  localparam int TIMEOUT = 200;
`ifdef TONE_DETECT_GLITCH_FILTER_EN
  localparam int LAT = 5;
  localparam bit GLITCH = 1'b1;
`else
  localparam int LAT = 3;
  localparam bit GLITCH = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             audio = 1'b0;
  logic [CNT_W-1:0] period;
  logic             period_valid;
  logic [1:0]       tone;
  logic [7:0]       siren_count;

  tone_detect #(
    .CLK_HZ    (1000),
    .TONE_LO_HZ(10),
    .TONE_HI_HZ(20),
    .TOL_CYC   (5),
    .CNT_W     (CNT_W)
  ) dut (
    .CLK100MHZ   (clk),
    .ck_rst      (rst_n),
    .audio_in    (audio),
    .period      (period),
    .period_valid(period_valid),
    .tone        (tone),
    .siren_count (siren_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         len;
    logic [1:0] tone;
    int         siren;
  } vec_t;

  typedef struct {
    int         period;
    logic [1:0] tone;
    int         siren;
    int         t0;
  } exp_t;

  vec_t vec[32];
  int   nvec = 0;
  exp_t sbq[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic add(input int len, input logic [1:0] t, input int s);
    vec[nvec] = '{len, t, s};
    nvec++;
  endtask

  task automatic push(input int idx);
    exp_t e;
    e.period = vec[idx].len;
    e.tone   = vec[idx].tone;
    e.siren  = vec[idx].siren;
    e.t0     = cyc;
    sbq.push_back(e);
  endtask

  // One period: rising edge now, high for half, optional 2-cycle glitch in the low half.
  task automatic drive_seg(input int len, input bit glitch);
    audio = 1'b1;
    repeat (len / 2) @(negedge clk);
    audio = 1'b0;
    if (glitch) begin
      repeat (10) @(negedge clk);
      audio = 1'b1;
      repeat (2) @(negedge clk);
      audio = 1'b0;
      repeat (len - len / 2 - 12) @(negedge clk);
    end else begin
      repeat (len - len / 2) @(negedge clk);
    end
  endtask

  // Rows first..last are consecutive periods; the first rise only arms.
  task automatic run_group(input int first, input int last, input bit glitch,
                           input bit timeout_end);
    drive_seg(vec[first].len, glitch);
    for (int i = first + 1; i <= last; i++) begin
      push(i - 1);
      drive_seg(vec[i].len, glitch);
    end
    push(last);
    audio = 1'b1;
    repeat (3) @(negedge clk);
    audio = 1'b0;
    if (timeout_end) begin
      repeat (TIMEOUT + 20) @(negedge clk);
      check("tone_after_timeout", int'(tone), 0);
      check("siren_after_timeout", int'(siren_count), vec[last].siren);
    end else begin
      repeat (10) @(negedge clk);
    end
    check("pending_strobes", sbq.size(), 0);
  endtask

  // Scoreboard consumer.
  always @(negedge clk) begin
    exp_t e;
    if (period_valid) begin
      if (sbq.size() == 0) begin
        check("unexpected_strobe", 1, 0);
      end else begin
        e = sbq.pop_front();
        check("period", int'(period), e.period);
        check("tone", int'(tone), int'(e.tone));
        check("siren_count", int'(siren_count), e.siren);
        check("latency", cyc - e.t0, LAT + 1);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    // group 1: five periods of 100 -> low confirmed on 2nd strobe
    add(100, 2'b00, 0); add(100, 2'b01, 0); add(100, 2'b01, 0);
    add(100, 2'b01, 0); add(100, 2'b01, 0);                        // 0..4
    // group 2: 4x50, 4x100, 4x50, one 103, 2x50
    add(50, 2'b00, 0);  add(50, 2'b10, 0);  add(50, 2'b10, 0);  add(50, 2'b10, 0);
    add(100, 2'b10, 0); add(100, 2'b01, 1); add(100, 2'b01, 1); add(100, 2'b01, 1);
    add(50, 2'b01, 1);  add(50, 2'b10, 2);  add(50, 2'b10, 2);  add(50, 2'b10, 2);
    add(103, 2'b10, 2); add(50, 2'b10, 2);  add(50, 2'b10, 2);     // 5..19
    // group 3: periods of 75 -> unknown
    add(75, 2'b00, 2);  add(75, 2'b11, 2);  add(75, 2'b11, 2);     // 20..22
    // group 4: high tone, then reset mid-period
    add(50, 2'b00, 2);  add(50, 2'b10, 2);  add(50, 2'b10, 2);     // 23..25
    // group 5: after reset
    add(100, 2'b00, 0); add(100, 2'b01, 0);                        // 26..27

    repeat (3) @(negedge clk);
    check("rst_period", int'(period), 0);
    check("rst_valid", int'(period_valid), 0);
    check("rst_tone", int'(tone), 0);
    check("rst_siren", int'(siren_count), 0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    run_group(0, 4, GLITCH, 1'b1);
    run_group(5, 19, 1'b0, 1'b1);
    run_group(20, 22, 1'b0, 1'b1);
    run_group(23, 25, 1'b0, 1'b0);
    check("tone_before_reset", int'(tone), 2);

    // Asynchronous reset mid-period: outputs clear before the next clock edge.
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_period", int'(period), 0);
    check("async_rst_valid", int'(period_valid), 0);
    check("async_rst_tone", int'(tone), 0);
    check("async_rst_siren", int'(siren_count), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    run_group(26, 27, 1'b0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
